// File: rtl/seq_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_cmd_scheduler                                                 |
// | Two-requester round-robin command scheduler driving a sequencer's          |
// | restart/pause/go_to_third lines. SEQ_WATCHDOG_EN enables LOOP watchdog.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module seq_cmd_scheduler #(
  parameter int CNT_W    = 4,
  parameter int WDOG_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [CNT_W-1:0] arg0,
  input  logic [CNT_W-1:0] arg1,
  input  logic             abort,
  input  logic             terminal,
  output logic [1:0]       grant,
  output logic             restart,
  output logic             pause,
  output logic             go_to_third,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int c_wd_w = $clog2(WDOG_CYC + 1);
  localparam logic [CNT_W:0]  c_cnt_one = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]  c_cnt_max = {1'b1, {CNT_W{1'b0}}};
  localparam logic [c_wd_w-1:0] c_wd_one = {{(c_wd_w-1){1'b0}}, 1'b1};
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WDOG_CYC - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam logic c_wdog_en = 1'b1;
`else
  localparam logic c_wdog_en = 1'b0;
`endif

  localparam logic [1:0] c_cmd_step    = 2'b00;
  localparam logic [1:0] c_cmd_restart = 2'b01;
  localparam logic [1:0] c_cmd_loop    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_RST  = 3'd2,
    S_LOOP = 3'd3,
    S_HOLD = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_prio;
  logic                r_aborting;
  logic [CNT_W:0]      r_cnt;
  logic [c_wd_w-1:0]   r_wd;
  logic [1:0]          r_grant;
  logic                r_restart;
  logic                r_pause;
  logic                r_go;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_win;
  logic [1:0]          w_cmd;
  logic [CNT_W-1:0]    w_arg;
  logic [CNT_W:0]      w_arg_full;
  logic                w_abort_now;

  // Contention goes to the pointer; otherwise whichever single requester is up.
  assign w_win      = (req[0] && req[1]) ? r_prio : req[1];
  assign w_cmd      = w_win ? cmd1 : cmd0;
  assign w_arg      = w_win ? arg1 : arg0;
  assign w_arg_full = (w_arg == '0) ? c_cnt_max : {1'b0, w_arg};

  // An abort's own restart cycle must not be re-armed by a held abort.
  assign w_abort_now = abort && (r_state != S_IDLE) &&
                       !((r_state == S_RST) && r_aborting);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_aborting <= 1'b0;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_grant    <= 2'b00;
      r_restart  <= 1'b0;
      r_pause    <= 1'b1;
      r_go       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_grant   <= 2'b00;
      r_restart <= 1'b0;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      if (w_abort_now) begin
        r_state    <= S_RST;
        r_aborting <= 1'b1;
        r_restart  <= 1'b1;
        r_pause    <= 1'b1;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pause <= 1'b1;
            r_busy  <= 1'b0;
            if (|req) begin
              r_grant <= w_win ? 2'b10 : 2'b01;
              r_prio  <= ~w_win;
              r_cnt   <= w_arg_full;
              r_wd    <= '0;
              r_busy  <= 1'b1;
              if (w_cmd == c_cmd_step) begin
                r_state <= S_STEP;
                r_pause <= 1'b0;
              end else if (w_cmd == c_cmd_restart) begin
                r_state   <= S_RST;
                r_restart <= 1'b1;
              end else if (w_cmd == c_cmd_loop) begin
                r_state <= S_LOOP;
                r_pause <= 1'b0;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_STEP, S_HOLD: begin
            if (r_cnt == c_cnt_one) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pause <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_RST: begin
            if (r_aborting) begin
              r_state    <= S_IDLE;
              r_aborting <= 1'b0;
              r_pause    <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pause <= 1'b1;
            end
          end
          S_LOOP: begin
            if (terminal) begin
              r_wd <= '0;
              if (r_cnt == c_cnt_one) begin
                r_cnt   <= '0;
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_pause <= 1'b1;
              end else begin
                r_cnt <= r_cnt - c_cnt_one;
                r_go  <= 1'b1;
              end
            end else if (c_wdog_en && (r_wd == c_wd_last)) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pause <= 1'b1;
            end else begin
              r_wd <= r_wd + c_wd_one;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_pause <= 1'b1;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_pause <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant       = r_grant;
  assign restart     = r_restart;
  assign pause       = r_pause;
  assign go_to_third = r_go;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_seq_cmd_scheduler                                              |
// | Directed self-checking bench for seq_cmd_scheduler.                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_seq_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, cmd0, cmd1;
  logic [3:0] arg0, arg1;
  logic       abort, terminal;
  logic [1:0] grant;
  logic       restart, pause, go_to_third, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Expected vectors: {grant[1:0], restart, pause, go_to_third, busy, done, err}
  localparam logic [7:0] c_idle      = 8'b00_0_1_0_0_0_0;
  localparam logic [7:0] c_run_g0    = 8'b01_0_0_0_1_0_0;
  localparam logic [7:0] c_run       = 8'b00_0_0_0_1_0_0;
  localparam logic [7:0] c_run_go    = 8'b00_0_0_1_1_0_0;
  localparam logic [7:0] c_done      = 8'b00_0_1_0_1_1_0;
  localparam logic [7:0] c_rst_g0    = 8'b01_1_1_0_1_0_0;
  localparam logic [7:0] c_rst_g1    = 8'b10_1_1_0_1_0_0;
  localparam logic [7:0] c_abort     = 8'b00_1_1_0_1_0_0;
  localparam logic [7:0] c_hold_g0   = 8'b01_0_1_0_1_0_0;
  localparam logic [7:0] c_hold      = 8'b00_0_1_0_1_0_0;

  seq_cmd_scheduler #(.CNT_W(4), .WDOG_CYC(8)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .arg0(arg0), .arg1(arg1), .abort(abort), .terminal(terminal),
    .grant(grant), .restart(restart), .pause(pause), .go_to_third(go_to_third),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {grant, restart, pause, go_to_third, busy, done, err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; cmd0 = 2'b00; cmd1 = 2'b00;
    arg0 = 4'd0; arg1 = 4'd0; abort = 1'b0; terminal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", c_idle);
    reset = 1'b0;
    tick("idle_after_reset", c_idle);

    // Round-robin: both requesting RESTART, requester 0 first after reset
    req = 2'b11; cmd0 = 2'b01; cmd1 = 2'b01;
    tick("rr_grant0_restart", c_rst_g0);
    tick("rr_done0", c_done);
    tick("rr_idle0", c_idle);
    tick("rr_grant1_restart", c_rst_g1);
    req = 2'b00;
    tick("rr_done1", c_done);
    tick("rr_idle1", c_idle);

    // STEP arg=3
    req = 2'b01; cmd0 = 2'b00; arg0 = 4'd3;
    tick("step_c1_grant", c_run_g0);
    req = 2'b00;
    tick("step_c2", c_run);
    tick("step_c3", c_run);
    tick("step_done", c_done);
    tick("step_idle", c_idle);

    // LOOP arg=2 with two terminal pulses
    req = 2'b01; cmd0 = 2'b10; arg0 = 4'd2;
    tick("loop_grant", c_run_g0);
    req = 2'b00;
    tick("loop_wait0", c_run);
    terminal = 1'b1;
    tick("loop_go_third", c_run_go);
    terminal = 1'b0;
    tick("loop_wait1", c_run);
    tick("loop_wait2", c_run);
    terminal = 1'b1;
    tick("loop_done_no_go", c_done);
    terminal = 1'b0;
    tick("loop_idle", c_idle);

    // STEP arg=5 aborted in its second cycle
    req = 2'b01; cmd0 = 2'b00; arg0 = 4'd5;
    tick("abort_step_c1", c_run_g0);
    req = 2'b00;
    tick("abort_step_c2", c_run);
    abort = 1'b1;
    tick("abort_restart", c_abort);
    abort = 1'b0;
    tick("abort_idle", c_idle);
    tick("abort_no_done", c_idle);

    // Abort in IDLE is ignored; simultaneous req granted (HOLD arg=1)
    abort = 1'b1; req = 2'b01; cmd0 = 2'b11; arg0 = 4'd1;
    tick("idle_abort_grant", c_hold_g0);
    abort = 1'b0; req = 2'b00;
    tick("hold1_done", c_done);
    tick("hold1_idle", c_idle);

    // LOOP arg=1 with terminal held low
    req = 2'b01; cmd0 = 2'b10; arg0 = 4'd1;
    tick("wd_loop_grant", c_run_g0);
    req = 2'b00;
`ifdef SEQ_WATCHDOG_EN
    for (int i = 0; i < 7; i++) tick("wd_loop_wait", c_run);
    tick("wd_expire_done_err", c_done | 8'b0000_0001);
    tick("wd_idle_err", c_idle | 8'b0000_0001);
    tick("wd_err_sticky", c_idle | 8'b0000_0001);
`else
    for (int i = 0; i < 12; i++) tick("loop_no_wdog_wait", c_run);
    abort = 1'b1;
    tick("loop_abort_restart", c_abort);
    abort = 1'b0;
    tick("loop_abort_idle", c_idle);
`endif

    // Reset during HOLD arg=0 (16 cycles)
    req = 2'b01; cmd0 = 2'b11; arg0 = 4'd0;
    tick("hold0_grant", c_hold_g0);
    req = 2'b00;
    for (int i = 0; i < 3; i++) tick("hold0_run", c_hold);
    #1;
    reset = 1'b1;
    #1;
    chk("hold0_async_reset", c_idle);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("post_reset_idle", c_idle);
    tick("post_reset_no_done", c_idle);

    // Pointer back at 0 after reset
    req = 2'b11; cmd0 = 2'b01; cmd1 = 2'b01;
    tick("post_reset_rr_grant0", c_rst_g0);
    req = 2'b00;
    tick("post_reset_done", c_done);
    tick("post_reset_idle2", c_idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_cmd_scheduler.md
SEQ_CMD_SCHEDULER -- requirements
Module: seq_cmd_scheduler

Interface
REQ-001 Parameters SHALL be:
- CNT_W, 4, width of command argument and step/loop counters.
- WDOG_CYC, 8, maximum cycles LOOP waits for terminal.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester command request; held until grant.
- cmd0, cmd1  in  2 each  command: 00 STEP, 01 RESTART, 10 LOOP, 11 HOLD.
- arg0, arg1  in  CNT_W each  command argument.
- abort  in  1  global abort.
- terminal  in  1  sequencer terminal-state flag.
- grant  out  2  one-hot, one-cycle accept pulse per requester.
- restart, pause, go_to_third  out  1 each  sequencer control lines.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky watchdog error flag.
REQ-003 Every output SHALL be registered.

Function
REQ-004 FSM states SHALL be IDLE, STEP, RST, LOOP, HOLD and DONE.
REQ-005 IDLE outputs SHALL be pause=1, restart=0, go_to_third=0, busy=0.
REQ-006 In IDLE with any req high at an edge, the FSM SHALL latch the winner's cmd/arg, enter the command state, and pulse grant[winner] for exactly the next cycle.
REQ-007 Arbitration SHALL be round-robin: if both req are high, the requester not granted last wins; priority pointer is 0 after reset.
REQ-008 A req that drops before its grant SHALL have no effect; req is ignored outside IDLE.
REQ-009 Argument 0 SHALL mean 2^CNT_W for STEP, LOOP and HOLD.
REQ-010 STEP SHALL drive pause=0, restart=0 for exactly arg cycles, then enter DONE.
REQ-011 RST SHALL drive restart=1, pause=1 for exactly 1 cycle, then enter DONE.
REQ-012 HOLD SHALL drive pause=1 for exactly arg cycles, then enter DONE.
REQ-013 LOOP SHALL drive pause=0 and wait for terminal=1.
REQ-014 On each terminal=1 in LOOP, the loop counter SHALL decrement.
- Counter nonzero after decrement: go_to_third=1 for the following cycle, then waiting resumes.
- Counter reaches 0: enter DONE with no go_to_third.
REQ-015 go_to_third SHALL be asserted only in LOOP and never together with restart.
REQ-016 DONE SHALL drive done=1 and pause=1 for 1 cycle, then return to IDLE; grant is never asserted in DONE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 abort=1 in any non-IDLE state SHALL, at the next edge, force restart=1 for 1 cycle with no done, then return to IDLE; abort wins over terminal and counter expiry in the same cycle.
REQ-019 abort in IDLE SHALL be ignored, and a simultaneous req SHALL be granted.

Reset
REQ-020 reset SHALL asynchronously force:
- state IDLE, round-robin pointer 0, counters 0;
- grant=00, restart=0, go_to_third=0, pause=1;
- busy=0, done=0, err=0.
REQ-021 reset mid-command SHALL discard the command without a done pulse.

Configuration
REQ-022 Macro SEQ_WATCHDOG_EN SHALL control the LOOP watchdog.
- Defined: a watchdog counter restarts on LOOP entry and after each terminal. If WDOG_CYC consecutive LOOP cycles pass without terminal, err is set (sticky until reset) and the FSM enters DONE.
- Undefined: LOOP waits indefinitely and err is tied 0.

Verification
REQ-023 Bench SHALL cover:
- req=01, cmd0=00, arg0=3 -> grant=01 one cycle; pause=0 for exactly 3 cycles; done pulse; busy back to 0.
- req=11 held across two commands (cmd0=01, cmd1=01) -> grant=01 first, then 10; restart pulses exactly once per command.
- cmd0=10, arg0=2, terminal pulsed twice -> one go_to_third pulse after the first terminal, none after the second; then done.
- STEP arg=5, abort raised in 2nd cycle -> restart=1 next cycle; no done; IDLE with pause=1.
- SEQ_WATCHDOG_EN defined, LOOP arg=1, terminal held 0 -> err=1 after 8 cycles, done pulse; err stays 1 until reset.
- reset asserted during HOLD arg=0 -> outputs immediately at reset values; no done.
